// File: rtl/ads_frame_assembler.sv
// ads_frame_assembler: assembles ADS1299 read-data frames into sign-extended words, committed atomically to an AXI-Stream FIFO
module ads_frame_assembler #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        sync_err,
  output logic        frame_drop,
  output logic [7:0]  frame_seq,
  output logic [15:0] err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, STATUS, CHAN, COMMIT, DISCARD} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_q, rd_d, used;
  logic [1:0] bcnt_q, bcnt_d;
  logic [3:0] ch_q, ch_d;
  logic [15:0] sh_q, sh_d, err_q, err_d;
  logic [7:0] seq_q, seq_d;
  logic serr_q, serr_d, drop_q, drop_d, wr_en;
  logic [AW-1:0] wr_addr;
  logic [32:0] wr_word;
  logic [32:0] mem_q [FIFO_DEPTH];
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    ch_d = ch_q;
    sh_d = sh_q;
    wr_spec_d = wr_spec_q;
    wr_commit_d = wr_commit_q;
    seq_d = seq_q;
    serr_d = 1'b0;
    drop_d = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_word = '0;
    used = '0;
    if (state_q == COMMIT) begin
      wr_commit_d = wr_spec_q;
      seq_d = seq_q + 8'd1;
      state_d = IDLE;
    end
    if (frame_start) begin
      if (state_q == STATUS || state_q == CHAN) begin
        wr_spec_d = wr_commit_q;
        drop_d = 1'b1;
      end
      used = wr_commit_d - rd_q;
      if (used <= (AW+1)'(FIFO_DEPTH - NUM_CH - 1)) begin
        state_d = STATUS;
        bcnt_d = 2'd0;
      end else begin
        state_d = DISCARD;
        drop_d = 1'b1;
      end
    end
    // a byte arriving with frame_start is byte 0 of the new frame
    if (byte_valid && (state_d == STATUS || state_d == CHAN)) begin
      sh_d = {sh_q[7:0], byte_data};
      if (state_d == STATUS && bcnt_d == 2'd0 && byte_data[7:4] != 4'hC) begin
        serr_d = 1'b1;
        state_d = DISCARD;
        wr_spec_d = wr_commit_d;
      end else if (bcnt_d == 2'd2) begin
        wr_en = 1'b1;
        wr_addr = wr_spec_d[AW-1:0];
        wr_word = state_d == STATUS ? {1'b0, seq_q, sh_q, byte_data}
                                    : {ch_d == 4'(NUM_CH - 1), {8{sh_q[15]}}, sh_q, byte_data};
        wr_spec_d = wr_spec_d + 1'b1;
        bcnt_d = 2'd0;
        if (state_d == STATUS) begin
          state_d = CHAN;
          ch_d = 4'd0;
        end else if (ch_d == 4'(NUM_CH - 1)) state_d = COMMIT;
        else ch_d = ch_d + 4'd1;
      end else bcnt_d = bcnt_d + 2'd1;
    end
    rd_d = rd_q + {{AW{1'b0}}, m_axis_tvalid && m_axis_tready};
    err_d = (serr_d || drop_d) && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      ch_q <= '0;
      sh_q <= '0;
      wr_spec_q <= '0;
      wr_commit_q <= '0;
      rd_q <= '0;
      seq_q <= '0;
      err_q <= '0;
      serr_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      ch_q <= ch_d;
      sh_q <= sh_d;
      wr_spec_q <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_q <= rd_d;
      seq_q <= seq_d;
      err_q <= err_d;
      serr_q <= serr_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge ACLK) if (wr_en) mem_q[wr_addr] <= wr_word;
  assign m_axis_tvalid = rd_q != wr_commit_q;
  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_q[AW-1:0]];
  assign sync_err = serr_q;
  assign frame_drop = drop_q;
  assign frame_seq = seq_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_ads_frame_assembler.sv
// tb_ads_frame_assembler: randomized frames against a queue-based reference of committed stream words
module tb_ads_frame_assembler;
  localparam int NUM_CH = 8;
  localparam int DEPTH = 32;
  localparam int FB = 3 + 3 * NUM_CH;
  typedef logic [7:0] frame_t [FB];
  logic ACLK = 1'b0, ARESETN = 1'b0, frame_start = 1'b0, byte_valid = 1'b0, m_axis_tready = 1'b0;
  logic [7:0] byte_data = '0;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, sync_err, frame_drop;
  logic [7:0] frame_seq;
  logic [15:0] err_cnt;
  int n_checks = 0, n_err = 0, n_serr = 0, n_drop = 0, exp_serr = 0, exp_drop = 0;
  int exp_seq = 0;
  bit rand_rdy = 1'b0;
  logic [32:0] exp_q[$], got_q[$];
  frame_t f;
  always #5 ACLK = ~ACLK;
  ads_frame_assembler #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .sync_err(sync_err),
    .frame_drop(frame_drop), .frame_seq(frame_seq), .err_cnt(err_cnt)
  );
  always @(negedge ACLK) if (ARESETN) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
    n_serr += int'(sync_err);
    n_drop += int'(frame_drop);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask
  task automatic gen(output frame_t fr, input bit good);
    for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
    if (good) fr[0][7:4] = 4'hC;
    else if (fr[0][7:4] == 4'hC) fr[0][7:4] = 4'h0;
  endtask
  task automatic run_frame(input frame_t fr, input int nb, input bit gaps);
    int occ;
    logic [23:0] s;
    int v;
    occ = exp_q.size() - got_q.size();
    if (DEPTH - occ < NUM_CH + 1) exp_drop++;
    else if (fr[0][7:4] != 4'hC) exp_serr++;
    else if (nb < FB) exp_drop++;
    else begin
      exp_q.push_back({1'b0, 8'(exp_seq), fr[0], fr[1], fr[2]});
      for (int c = 0; c < NUM_CH; c++) begin
        s = {fr[3+3*c], fr[4+3*c], fr[5+3*c]};
        v = s >= 24'h800000 ? int'(s) - 32'h1000000 : int'(s);
        exp_q.push_back({c == NUM_CH - 1, 32'(v)});
      end
      exp_seq = (exp_seq + 1) % 256;
    end
    for (int i = 0; i < nb; i++) begin
      frame_start = i == 0;
      byte_valid = 1'b1;
      byte_data = fr[i];
      tick();
      frame_start = 1'b0;
      byte_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic drain(input bit rnd);
    int cyc = 0;
    rand_rdy = rnd;
    m_axis_tready = 1'b1;
    while (got_q.size() < exp_q.size() && cyc < 3000) begin
      tick();
      cyc++;
    end
    rand_rdy = 1'b0;
    m_axis_tready = 1'b1;
    repeat (6) tick();
    chk("drain_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    chk("sync_err_pulses", 64'(n_serr), 64'(exp_serr));
    chk("frame_drop_pulses", 64'(n_drop), 64'(exp_drop));
    chk("err_cnt", 64'(err_cnt), 64'(exp_serr + exp_drop));
    chk("frame_seq", 64'(frame_seq), 64'(exp_seq));
    m_axis_tready = 1'b0;
  endtask
  task automatic clearq();
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int cyc;
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_seq", 64'(frame_seq), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_pulses", 64'({sync_err, frame_drop}), 64'd0);
    tick();
    ARESETN = 1'b1;
    tick();
    f[0] = 8'hC0; f[1] = 8'h00; f[2] = 8'h00;
    f[3] = 8'h12; f[4] = 8'h34; f[5] = 8'h56;
    for (int c = 1; c < NUM_CH; c++) begin
      f[3+3*c] = 8'h00; f[4+3*c] = 8'h00; f[5+3*c] = 8'(c);
    end
    run_frame(f, FB, 1'b0);
    @(negedge ACLK);
    chk("tvalid_in_commit", 64'(m_axis_tvalid), 64'd0);
    @(negedge ACLK);
    chk("tvalid_after_commit", 64'(m_axis_tvalid), 64'd1);
    chk("first_header", 64'(m_axis_tdata), 64'h00C00000);
    chk("first_tlast", 64'(m_axis_tlast), 64'd0);
    chk("seq_after_commit", 64'(frame_seq), 64'd1);
    tick();
    drain(1'b0);
    chk("ch0_word", 64'(got_q[1]), 64'h0_00123456);
    chk("last_word", 64'(got_q[8]), 64'h1_00000007);
    clearq();
    gen(f, 1'b1);
    f[3] = 8'h80; f[4] = 8'h00; f[5] = 8'h00;
    f[6] = 8'h7F; f[7] = 8'hFF; f[8] = 8'hFF;
    f[9] = 8'hFF; f[10] = 8'hFF; f[11] = 8'hFF;
    run_frame(f, FB, 1'b1);
    drain(1'b0);
    chk("sext_800000", 64'(got_q[1][31:0]), 64'hFF800000);
    chk("sext_7fffff", 64'(got_q[2][31:0]), 64'h007FFFFF);
    chk("sext_ffffff", 64'(got_q[3][31:0]), 64'hFFFFFFFF);
    clearq();
    gen(f, 1'b1);
    f[0] = 8'h00;
    run_frame(f, FB, 1'b0);
    gen(f, 1'b1);
    run_frame(f, FB, 1'b1);
    drain(1'b0);
    clearq();
    gen(f, 1'b1);
    run_frame(f, 10, 1'b0);
    gen(f, 1'b1);
    run_frame(f, FB, 1'b0);
    drain(1'b1);
    clearq();
    for (int k = 0; k < 4; k++) begin
      gen(f, 1'b1);
      run_frame(f, FB, 1'b0);
    end
    repeat (4) tick();
    chk("stall_words_held", 64'(m_axis_tvalid), 64'd1);
    drain(1'b0);
    chk("stall_27_words", 64'(got_q.size()), 64'd27);
    clearq();
    gen(f, 1'b1);
    run_frame(f, FB, 1'b0);
    gen(f, 1'b1);
    run_frame(f, 8, 1'b0);
    tick();
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_seq", 64'(frame_seq), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    clearq();
    exp_seq = 0; exp_serr = 0; exp_drop = 0; n_serr = 0; n_drop = 0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int r = $urandom_range(0, 9);
      cyc = 0;
      while (exp_q.size() - got_q.size() > DEPTH - 2 * (NUM_CH + 1) && cyc < 500) begin
        tick();
        cyc++;
      end
      gen(f, r >= 2);
      run_frame(f, (r == 2 || r == 3) ? $urandom_range(1, FB - 1) : FB, 1'b1);
    end
    gen(f, 1'b1);
    run_frame(f, FB, 1'b1);
    drain(1'b1);
    clearq();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
